// File: rtl/cache_pkg.sv
// Shared definitions for the two-way cache refill controller: address-field
// width helpers, the default-geometry address layout and the refill FSM states.
package cache_pkg;

  // Bits needed to index a word inside a block of block_size bytes.
  function automatic int word_bits(input int block_size);
    return $clog2(block_size / 4);
  endfunction

  // Bits needed to index a set.
  function automatic int set_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag width once byte, word and set fields are removed from the address.
  function automatic int tag_bits(input int addr_size, input int num_sets, input int block_size);
    return addr_size - set_bits(num_sets) - word_bits(block_size) - 2;
  endfunction

  localparam int DEF_ADDR_SIZE  = 32;
  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_BLOCK_SIZE = 32;
  localparam int DEF_WORD_BITS  = word_bits(DEF_BLOCK_SIZE);
  localparam int DEF_SET_BITS   = set_bits(DEF_NUM_SETS);
  localparam int DEF_TAG_BITS   = tag_bits(DEF_ADDR_SIZE, DEF_NUM_SETS, DEF_BLOCK_SIZE);

  // Default-geometry address view; packed fields listed MSB first, so the
  // byte offset occupies bits [1:0], followed by word, set and tag.
  typedef struct packed {
    logic [DEF_TAG_BITS-1:0]  tag;
    logic [DEF_SET_BITS-1:0]  set;
    logic [DEF_WORD_BITS-1:0] word;
    logic [1:0]               byte_sel;
  } cache_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RESP   = 2'd2,
    COMMIT = 2'd3
  } refill_state_t;

endpackage

// File: rtl/two_way_cache_refill_ctrl.sv
// Miss-handling engine for the two-way set-associative data cache.
// Fetches a whole block one word at a time, writes it into the victim way,
// commits tag/valid and pulses replace to the LRU unit.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN (start the refill at the
// missing word and expose crit_valid for early restart).
//
// state  | meaning
// IDLE   | waiting for a miss; responses ignored
// REQ    | word request presented, held until accepted
// RESP   | one request outstanding, waiting for its data
// COMMIT | tag/valid write, LRU replace and done pulse
module two_way_cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int NUM_SETS   = 16,
  parameter int BLOCK_SIZE = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          miss,
  input  logic [ADDR_SIZE-1:0]                                          miss_addr,
  input  logic                                                          preferred,
  output logic                                                          busy,
  output logic                                                          refill_done,
  output logic                                                          replace,
  output logic [ADDR_SIZE-1:0]                                          lru_addr,
  output logic                                                          mem_req_valid,
  input  logic                                                          mem_req_ready,
  output logic [ADDR_SIZE-1:0]                                          mem_req_addr,
  input  logic                                                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                                         mem_rsp_data,
  output logic                                                          data_we,
  output logic                                                          data_way,
  output logic [set_bits(NUM_SETS)-1:0]                                 data_set,
  output logic [word_bits(BLOCK_SIZE)-1:0]                              data_word,
  output logic [DATA_WIDTH-1:0]                                         data_wdata,
  output logic                                                          tag_we,
  output logic [tag_bits(ADDR_SIZE, NUM_SETS, BLOCK_SIZE)-1:0]          tag_wdata
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic                                                          crit_valid
`endif
);

  localparam int WW    = word_bits(BLOCK_SIZE);
  localparam int SW    = set_bits(NUM_SETS);
  localparam int TW    = tag_bits(ADDR_SIZE, NUM_SETS, BLOCK_SIZE);
  localparam int WORDS = BLOCK_SIZE / 4;
  localparam logic [WW:0] LAST_CNT = (WW+1)'(WORDS - 1);

  refill_state_t        state;
  logic [ADDR_SIZE-1:0] addr_q;
  logic                 way_q;
  logic [WW-1:0]        cnt;
  // One bit wider than cnt so it never wraps when the word index does.
  logic [WW:0]          done_cnt;
  logic [WW-1:0]        start_word;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign start_word = miss_addr[WW+1:2];
`else
  assign start_word = '0;
`endif

  // Refill sequencing with registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      way_q         <= 1'b0;
      cnt           <= '0;
      done_cnt      <= '0;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      tag_we        <= 1'b0;
      replace       <= 1'b0;
      refill_done   <= 1'b0;
    end else begin
      tag_we      <= 1'b0;
      replace     <= 1'b0;
      refill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            addr_q        <= miss_addr;
            way_q         <= preferred;
            cnt           <= start_word;
            done_cnt      <= '0;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (mem_rsp_valid) begin
            done_cnt <= done_cnt + 1'b1;
            if (done_cnt == LAST_CNT) begin
              tag_we      <= 1'b1;
              replace     <= 1'b1;
              refill_done <= 1'b1;
              state       <= COMMIT;
            end else begin
              cnt           <= cnt + 1'b1;
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The data write happens in the response cycle itself, so it is decoded
  // from the live response rather than registered.
  assign data_we      = (state == RESP) && mem_rsp_valid;
  assign data_wdata   = data_we ? mem_rsp_data : '0;
  assign data_way     = way_q;
  assign data_set     = addr_q[WW+2 +: SW];
  assign data_word    = cnt;
  assign tag_wdata    = addr_q[ADDR_SIZE-1 -: TW];
  assign lru_addr     = addr_q;
  assign mem_req_addr = mem_req_valid ? {addr_q[ADDR_SIZE-1:WW+2], cnt, 2'b00} : '0;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign crit_valid = data_we && (done_cnt == '0);
`endif

endmodule

// File: tb/tb_two_way_cache_refill_ctrl.sv
// Directed scoreboard bench for two_way_cache_refill_ctrl (default geometry).
// Also builds with CACHE_CRITICAL_WORD_FIRST_EN, where word order and
// crit_valid are checked as well.
module tb_two_way_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        preferred = 1'b0;
  logic        busy, refill_done, replace;
  logic [31:0] lru_addr;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        data_we, data_way;
  logic [3:0]  data_set;
  logic [2:0]  data_word;
  logic [31:0] data_wdata;
  logic        tag_we;
  logic [22:0] tag_wdata;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  logic        crit_valid;
`endif

  two_way_cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .preferred(preferred),
    .busy(busy), .refill_done(refill_done), .replace(replace), .lru_addr(lru_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .data_we(data_we), .data_way(data_way), .data_set(data_set), .data_word(data_word),
    .data_wdata(data_wdata), .tag_we(tag_we), .tag_wdata(tag_wdata)
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    , .crit_valid(crit_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rep_cnt = 0;
  int tag_cnt = 0;

  // Pulse counters, sampled mid-cycle so duplicates are visible.
  always @(negedge clk) begin
    if (data_we === 1'b1) we_cnt++;
    if (replace === 1'b1) rep_cnt++;
    if (tag_we === 1'b1) tag_cnt++;
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  word;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {busy, refill_done, replace, mem_req_valid, data_we, data_way, tag_we,
            data_set, data_word, tag_wdata, 14'h0} | {32'h0, lru_addr | mem_req_addr | data_wdata};
  endfunction

  // One complete refill. stall_word/toggle_word/abort_word are issue-order
  // indices (-1 disables).
  task automatic do_refill(input logic [31:0] addr, input logic pref, input logic [3:0] exp_set,
                           input logic [22:0] exp_tag, input int stall_word, input int stall_n,
                           input int toggle_word, input int abort_word);
    int   cyc;
    int   we0, rep0, tag0;
    int   exp_cyc;
    exp_t e;
    logic [2:0] start;
    we0  = we_cnt;
    rep0 = rep_cnt;
    tag0 = tag_cnt;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    start = addr[4:2];
`else
    start = 3'd0;
`endif
    for (int i = 0; i < WORDS; i++) begin
      e.word = start + 3'(i);
      e.addr = {addr[31:5], e.word, 2'b00};
      e.data = 32'hC0DE_0000 ^ e.addr;
      sb.push_back(e);
    end
    exp_cyc = 2 * WORDS + 1 + ((stall_word >= 0) ? stall_n : 0);

    check("busy_before_miss", 64'(busy), 64'(0));
    miss = 1'b1;
    miss_addr = addr;
    preferred = pref;
    cyc = 0;
    tick();
    cyc++;
    miss = 1'b0;
    miss_addr = $urandom;
    check("busy_rise", 64'(busy), 64'(1));

    for (int k = 0; k < WORDS; k++) begin
      e = sb[0];
      if (k == toggle_word) preferred = ~pref;
      check("req_valid", 64'(mem_req_valid), 64'(1));
      check("req_addr", 64'(mem_req_addr), 64'(e.addr));
      check("no_early_done", 64'(refill_done), 64'(0));
      if (k == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          cyc++;
          check("stall_valid", 64'(mem_req_valid), 64'(1));
          check("stall_addr", 64'(mem_req_addr), 64'(e.addr));
          check("stall_no_we", 64'(data_we), 64'(0));
        end
      end
      mem_req_ready = 1'b1;
      tick();
      cyc++;
      mem_req_ready = 1'b0;
      check("req_dropped", 64'(mem_req_valid), 64'(0));

      if (k == abort_word) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = e.data;
        rst = 1'b1;
        #1;
        check("reset_outputs_zero", all_outputs(), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check("late_rsp_no_we", 64'(data_we), 64'(0));
        tick();
        mem_rsp_valid = 1'b0;
        check("abort_we_count", 64'(we_cnt - we0), 64'(k));
        check("abort_no_replace", 64'(rep_cnt - rep0), 64'(0));
        check("abort_no_tag_we", 64'(tag_cnt - tag0), 64'(0));
        check("abort_busy_low", 64'(busy), 64'(0));
        sb.delete();
        return;
      end

      mem_rsp_valid = 1'b1;
      mem_rsp_data  = e.data;
      #1;
      check("data_we", 64'(data_we), 64'(1));
      check("data_word", 64'(data_word), 64'(e.word));
      check("data_way", 64'(data_way), 64'(pref));
      check("data_set", 64'(data_set), 64'(exp_set));
      check("data_wdata", 64'(data_wdata), 64'(e.data));
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      check("crit_valid", 64'(crit_valid), 64'(k == 0));
`endif
      void'(sb.pop_front());
      tick();
      cyc++;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end

    check("commit_latency", 64'(cyc), 64'(exp_cyc));
    check("refill_done", 64'(refill_done), 64'(1));
    check("tag_we", 64'(tag_we), 64'(1));
    check("replace", 64'(replace), 64'(1));
    check("tag_wdata", 64'(tag_wdata), 64'(exp_tag));
    check("commit_set", 64'(data_set), 64'(exp_set));
    check("commit_way", 64'(data_way), 64'(pref));
    check("lru_addr", 64'(lru_addr), 64'(addr));
    tick();
    check("done_pulse_end", 64'(refill_done), 64'(0));
    check("replace_pulse_end", 64'(replace), 64'(0));
    check("busy_fall", 64'(busy), 64'(0));
    check("we_pulses", 64'(we_cnt - we0), 64'(WORDS));
    check("replace_pulses", 64'(rep_cnt - rep0), 64'(1));
    check("tag_we_pulses", 64'(tag_cnt - tag0), 64'(1));
  endtask

  initial begin
    cache_addr_t a;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_zero", all_outputs(), 64'(0));
    tick();
    tick();
    check("reset_held_zero", all_outputs(), 64'(0));
    rst = 1'b0;
    tick();

    // Basic refill: 0x1234, way 1 -> set 1, tag 9.
    do_refill(32'h0000_1234, 1'b1, 4'd1, 23'd9, -1, 0, -1, -1);
    // Ready held low for 3 cycles on the third request.
    do_refill(32'h0000_1234, 1'b1, 4'd1, 23'd9, 2, 3, -1, -1);
    // Reset while word 4 is outstanding.
    do_refill(32'h0000_1234, 1'b0, 4'd1, 23'd9, -1, 0, -1, 4);
    tick();
    // preferred flips mid-refill; victim stays way 0.
    do_refill(32'h0000_1234, 1'b0, 4'd1, 23'd9, -1, 0, 3, -1);
    // Back-to-back misses; the second maps to set 0, tag 0x28.
    do_refill(32'h0000_1234, 1'b1, 4'd1, 23'd9, -1, 0, -1, -1);
    a = 32'h0000_5000;
    do_refill(32'h0000_5000, 1'b0, a.set, a.tag, -1, 0, -1, -1);
    check("second_tag_const", 64'(tag_wdata), 64'(23'h28));
    check("second_set_const", 64'(data_set), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
